// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR trap/return sequencer:
//   - privilege encodings (PRIV_U/S/M)
//   - redirect_sel encodings (mtvec/stvec/mepc/sepc)
//   - interrupt codes and their fixed priority list (highest first)
//   - sequencer state enum and the latched request record
// ---------------------------------------------------------------------------
package csr_pkg;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    localparam logic [1:0] SEL_MTVEC = 2'd0;
    localparam logic [1:0] SEL_STVEC = 2'd1;
    localparam logic [1:0] SEL_MEPC  = 2'd2;
    localparam logic [1:0] SEL_SEPC  = 2'd3;

    localparam logic [3:0] IRQ_SSI = 4'd1;
    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_STI = 4'd5;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_SEI = 4'd9;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    // Interrupt arbitration order, highest priority first. Codes not listed
    // here are never taken.
    localparam int IRQ_NUM = 6;
    localparam logic [3:0] IRQ_PRIO [IRQ_NUM] =
        '{IRQ_MEI, IRQ_MSI, IRQ_MTI, IRQ_SEI, IRQ_SSI, IRQ_STI};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT,
        ST_REDIRECT
    } state_e;

    typedef enum logic [1:0] {
        REQ_EXC,
        REQ_IRQ,
        REQ_MRET,
        REQ_SRET
    } req_kind_e;

    // Request captured in IDLE and replayed at COMMIT/REDIRECT.
    typedef struct packed {
        req_kind_e  kind;
        logic       target_s;   // trap goes to S-mode (meaningless for returns)
        logic [4:0] code;       // exception or interrupt code
    } req_t;

endpackage

// File: rtl/irq_select.sv
// ---------------------------------------------------------------------------
// irq_select
// Combinational interrupt resolver: walks the fixed priority list and picks
// the highest-priority pending interrupt that is enabled for its delegated
// target privilege.
//
// Ports:
//   irq_pend     in  16  pending & enabled interrupts (bit n = code n)
//   mideleg      in  16  interrupt delegation to S-mode
//   mstatus_mie  in  1   global M interrupt enable
//   mstatus_sie  in  1   global S interrupt enable
//   priv         in  2   current privilege
//   valid        out 1   an interrupt is selected
//   code         out 4   selected interrupt code
//   target_s     out 1   selected interrupt traps to S-mode
// ---------------------------------------------------------------------------
module irq_select
    import csr_pkg::*;
(
    input  logic [15:0] irq_pend,
    input  logic [15:0] mideleg,
    input  logic        mstatus_mie,
    input  logic        mstatus_sie,
    input  logic [1:0]  priv,
    output logic        valid,
    output logic [3:0]  code,
    output logic        target_s
);

    logic m_en;
    logic s_en;

    // M-targeted interrupts are always taken below M; in M only with MIE.
    assign m_en = (priv != PRIV_M) || mstatus_mie;
    // S-targeted interrupts are never taken from M-mode.
    assign s_en = (priv == PRIV_U) || ((priv == PRIV_S) && mstatus_sie);

    always_comb begin
        // NOTE: every output gets a default before any conditional assignment;
        // a path that leaves one unassigned would infer a latch.
        valid    = 1'b0;
        code     = 4'd0;
        target_s = 1'b0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            if (!valid && irq_pend[IRQ_PRIO[i]]) begin
                if (mideleg[IRQ_PRIO[i]] ? s_en : m_en) begin
                    valid    = 1'b1;
                    code     = IRQ_PRIO[i];
                    target_s = mideleg[IRQ_PRIO[i]];
                end
            end
        end
    end

endmodule

// File: rtl/trap_seq.sv
// ---------------------------------------------------------------------------
// trap_seq
// Trap/return sequencer for the CSR unit. Captures one exception, interrupt,
// mret or sret in IDLE, stalls and drains the pipeline, emits a one-cycle
// commit strobe for the epc/cause/privilege registers, then holds a PC
// redirect request until the PC unit acknowledges it.
//
// Optional feature: define TRAP_SEQ_TVAL_EN to add tval_in/trap_tval, which
// carry the faulting value of an exception through to the commit cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   exc_valid/code  exception from the retiring instruction
//   mret_req        mret retiring
//   sret_req        sret retiring
//   irq_pend        pending & enabled interrupts
//   mideleg/medeleg interrupt / exception delegation
//   mstatus_mie/sie global interrupt enables
//   priv            current privilege
//   pipe_idle       nothing in flight past decode
//   redirect_ack    PC unit accepted the redirect
//   stall           hold fetch/decode (DRAIN, COMMIT, REDIRECT)
//   flush           one-cycle pipeline flush (COMMIT)
//   trap_target_m/s one-cycle commit strobe for an M / S trap
//   next_pc         epc takes the following instruction (interrupts)
//   trap_cause      {interrupt, zeros, code}, valid with the strobe
//   new_priv        privilege after trap/return, valid at commit
//   ret_commit      one-cycle; bit0 = mret, bit1 = sret
//   redirect_valid  PC redirect request
//   redirect_sel    0 mtvec, 1 stvec, 2 mepc, 3 sepc
//   drain_timeout   sticky: drain gave up waiting for pipe_idle
//   tval_in         (TRAP_SEQ_TVAL_EN) exception value
//   trap_tval       (TRAP_SEQ_TVAL_EN) exception value at commit, else 0
// ---------------------------------------------------------------------------
module trap_seq
    import csr_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int DRAIN_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic [4:0]      exc_code,
    input  logic            mret_req,
    input  logic            sret_req,
    input  logic [15:0]     irq_pend,
    input  logic [15:0]     mideleg,
    input  logic [15:0]     medeleg,
    input  logic            mstatus_mie,
    input  logic            mstatus_sie,
    input  logic [1:0]      priv,
    input  logic            pipe_idle,
    input  logic            redirect_ack,
    output logic            stall,
    output logic            flush,
    output logic            trap_target_m,
    output logic            trap_target_s,
    output logic            next_pc,
    output logic [XLEN-1:0] trap_cause,
    output logic [1:0]      new_priv,
    output logic [1:0]      ret_commit,
    output logic            redirect_valid,
    output logic [1:0]      redirect_sel,
`ifdef TRAP_SEQ_TVAL_EN
    input  logic [XLEN-1:0] tval_in,
    output logic [XLEN-1:0] trap_tval,
`endif
    output logic            drain_timeout
);

    localparam int CNT_W = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_MAX);

    state_e          state, state_nxt;
    req_t            req_q, req_nxt;
    logic            take;
    logic [CNT_W-1:0] cnt;
    logic            drain_expired;

    logic            irq_valid;
    logic [3:0]      irq_code;
    logic            irq_target_s;
    logic            exc_deleg;

    irq_select u_irq_select (
        .irq_pend    (irq_pend),
        .mideleg     (mideleg),
        .mstatus_mie (mstatus_mie),
        .mstatus_sie (mstatus_sie),
        .priv        (priv),
        .valid       (irq_valid),
        .code        (irq_code),
        .target_s    (irq_target_s)
    );

    // medeleg only covers codes 0..15; higher codes always trap to M.
    assign exc_deleg = !exc_code[4] && medeleg[exc_code[3:0]];

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state         <= ST_IDLE;
            req_q         <= '0;
            cnt           <= '0;
            drain_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                req_q <= req_nxt;
                cnt   <= '0;
            end else if (state == ST_DRAIN && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (drain_expired) begin
                drain_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        take           = 1'b0;
        req_nxt        = req_q;
        drain_expired  = 1'b0;
        stall          = (state != ST_IDLE);
        flush          = 1'b0;
        trap_target_m  = 1'b0;
        trap_target_s  = 1'b0;
        next_pc        = 1'b0;
        trap_cause     = '0;
        new_priv       = PRIV_M;
        ret_commit     = 2'b00;
        redirect_valid = 1'b0;
        redirect_sel   = SEL_MTVEC;

        case (state)
            ST_IDLE: begin
                if (exc_valid) begin
                    take    = 1'b1;
                    req_nxt = '{kind: REQ_EXC, target_s: exc_deleg && (priv != PRIV_M),
                                code: exc_code};
                end else if (mret_req) begin
                    take    = 1'b1;
                    req_nxt = '{kind: REQ_MRET, target_s: 1'b0, code: 5'd0};
                end else if (sret_req) begin
                    take    = 1'b1;
                    req_nxt = '{kind: REQ_SRET, target_s: 1'b0, code: 5'd0};
                end else if (irq_valid) begin
                    take    = 1'b1;
                    req_nxt = '{kind: REQ_IRQ, target_s: irq_target_s,
                                code: {1'b0, irq_code}};
                end
                if (take) begin
                    state_nxt = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Timeout is flagged only when the counter, not pipe_idle,
                // is what ends the drain.
                drain_expired = (cnt == CNT_MAX) && !pipe_idle;
                if (pipe_idle || cnt == CNT_MAX) begin
                    state_nxt = ST_COMMIT;
                end
            end

            ST_COMMIT: begin
                flush = 1'b1;
                case (req_q.kind)
                    REQ_EXC, REQ_IRQ: begin
                        trap_target_m             = !req_q.target_s;
                        trap_target_s             = req_q.target_s;
                        next_pc                   = (req_q.kind == REQ_IRQ);
                        trap_cause[XLEN-1]        = (req_q.kind == REQ_IRQ);
                        trap_cause[4:0]           = req_q.code;
                        new_priv                  = req_q.target_s ? PRIV_S : PRIV_M;
                    end
                    REQ_MRET: begin
                        ret_commit = 2'b01;
                        new_priv   = PRIV_U;
                    end
                    default: begin
                        ret_commit = 2'b10;
                        new_priv   = PRIV_U;
                    end
                endcase
                state_nxt = ST_REDIRECT;
            end

            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                case (req_q.kind)
                    REQ_MRET: redirect_sel = SEL_MEPC;
                    REQ_SRET: redirect_sel = SEL_SEPC;
                    default:  redirect_sel = req_q.target_s ? SEL_STVEC : SEL_MTVEC;
                endcase
                if (redirect_ack) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef TRAP_SEQ_TVAL_EN
    logic [XLEN-1:0] tval_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tval_q <= '0;
        end else if (state == ST_IDLE && exc_valid) begin
            tval_q <= tval_in;
        end
    end

    assign trap_tval = (state == ST_COMMIT && req_q.kind == REQ_EXC) ? tval_q : '0;
`endif

endmodule
